// File: rtl/noc_offchip_arbiter.sv
// Shares one off-chip NoC2/NoC3 channel pair between NUM_REQ requesters.
// NoC2 is arbitrated round-robin with whole-packet locking; NoC3 responses are routed by header chipid.
//
// state  | meaning
// R_IDLE | no grant; pick the next requester round-robin (one bubble cycle)
// R_HDR  | granted requester passes its header flit through
// R_BODY | granted requester passes body flits, rcnt counts down to the tail
// S_HDR  | next response flit is a header; route or drop by chipid
// S_BODY | response body flits follow the latched port or are sunk
module noc_offchip_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 64,
  parameter int CHIPID_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_val,
  input  logic [NUM_REQ*DW-1:0] req_dat,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic                  br_noc2_val,
  output logic [DW-1:0]         br_noc2_dat,
  input  logic                  br_noc2_rdy,
  input  logic                  br_noc3_val,
  input  logic [DW-1:0]         br_noc3_dat,
  output logic                  br_noc3_rdy,
  output logic [NUM_REQ-1:0]    rsp_val,
  output logic [DW-1:0]         rsp_dat,
  input  logic [NUM_REQ-1:0]    rsp_rdy,
  output logic                  rsp_drop
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {R_IDLE, R_HDR, R_BODY} r_state_t;
  typedef enum logic {S_HDR, S_BODY} s_state_t;

  r_state_t      rstate;
  s_state_t      sstate;
  logic [GW-1:0] grant, rr_ptr, winner, cand, port;
  logic [7:0]    rcnt, scnt;
  logic          any_req, drop, req_hs, rsp_hs, in_range;
  logic [DW-1:0] gnt_dat;
  logic [13:0]   idx;

  // Descending scan so the lowest offset from rr_ptr+1 wins.
  always_comb begin
    winner  = rr_ptr;
    cand    = rr_ptr;
    any_req = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_val[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign gnt_dat = req_dat[grant*DW +: DW];

  always_comb begin
    req_rdy     = '0;
    br_noc2_val = 1'b0;
    br_noc2_dat = '0;
    if (rstate != R_IDLE) begin
      br_noc2_val    = req_val[grant];
      br_noc2_dat    = gnt_dat;
      req_rdy[grant] = br_noc2_rdy;
    end
  end

  assign req_hs = br_noc2_val & br_noc2_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      grant  <= '0;
      rr_ptr <= GW'(NUM_REQ - 1);
      rcnt   <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (any_req) begin
          grant  <= winner;
          rr_ptr <= winner;
          rstate <= R_HDR;
        end
        R_HDR: if (req_hs) begin
          if (gnt_dat[29:22] == 8'd0) rstate <= R_IDLE;
          else begin
            rcnt   <= gnt_dat[29:22];
            rstate <= R_BODY;
          end
        end
        R_BODY: if (req_hs) begin
          rcnt <= rcnt - 8'd1;
          if (rcnt == 8'd1) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign idx      = br_noc3_dat[63:50] - 14'(CHIPID_BASE);
  assign in_range = (idx < 14'(NUM_REQ));
  assign rsp_dat  = br_noc3_dat;

  // Response handshake outputs are held off while reset is asserted.
  always_comb begin
    rsp_val     = '0;
    br_noc3_rdy = 1'b0;
    rsp_drop    = 1'b0;
    if (rst_n) begin
      if (sstate == S_HDR) begin
        if (in_range) begin
          rsp_val[idx[GW-1:0]] = br_noc3_val;
          br_noc3_rdy          = rsp_rdy[idx[GW-1:0]];
        end else begin
          br_noc3_rdy = 1'b1;
          rsp_drop    = br_noc3_val;
        end
      end else if (drop) begin
        br_noc3_rdy = 1'b1;
      end else begin
        rsp_val[port] = br_noc3_val;
        br_noc3_rdy   = rsp_rdy[port];
      end
    end
  end

  assign rsp_hs = br_noc3_val & br_noc3_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sstate <= S_HDR;
      port   <= '0;
      drop   <= 1'b0;
      scnt   <= '0;
    end else begin
      case (sstate)
        S_HDR: if (rsp_hs && br_noc3_dat[29:22] != 8'd0) begin
          port   <= idx[GW-1:0];
          drop   <= !in_range;
          scnt   <= br_noc3_dat[29:22];
          sstate <= S_BODY;
        end
        S_BODY: if (rsp_hs) begin
          scnt <= scnt - 8'd1;
          if (scnt == 8'd1) sstate <= S_HDR;
        end
        default: sstate <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_offchip_arbiter.sv
// Randomised bench for noc_offchip_arbiter with a packet-level reference model
// and directed scenarios for arbitration order, locking, routing, drop and reset.
module tb_noc_offchip_arbiter;
  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int BASE = 0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]    req_val, req_rdy, rsp_val, rsp_rdy;
  logic [N*DW-1:0] req_dat;
  logic            br_noc2_val, br_noc2_rdy, br_noc3_val, br_noc3_rdy, rsp_drop;
  logic [DW-1:0]   br_noc2_dat, br_noc3_dat, rsp_dat;

  always #5 clk = ~clk;

  noc_offchip_arbiter #(.NUM_REQ(N), .DW(DW), .CHIPID_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_dat(req_dat), .req_rdy(req_rdy),
    .br_noc2_val(br_noc2_val), .br_noc2_dat(br_noc2_dat), .br_noc2_rdy(br_noc2_rdy),
    .br_noc3_val(br_noc3_val), .br_noc3_dat(br_noc3_dat), .br_noc3_rdy(br_noc3_rdy),
    .rsp_val(rsp_val), .rsp_dat(rsp_dat), .rsp_rdy(rsp_rdy), .rsp_drop(rsp_drop)
  );

  int total = 0, bad = 0, cyc = 0;
  logic [63:0] q_req [N][$];
  logic [63:0] q_rsp [$];
  int p_val = 100, p_b2rdy = 100, p_b3val = 100, p_rrdy = 100;
  logic [N-1:0] kill = '0, rrdy_kill = '0;
  logic b2_kill = 1'b0;

  // Reference model: packet owner and flits still owed, response routing target.
  int m_owner = -1, m_last = N - 1, m_left = 0;
  bit m_hdr = 1'b0;
  bit r_hdr = 1'b1, r_drop = 1'b0;
  int r_port = 0, r_left = 0;

  int grant_log[$];
  int src_log[$];
  int hs_cyc[$];
  int first_val_cyc = -1;
  int dut_rsp_hs[N];
  int dut_drop_cnt = 0, dut_b3_hs = 0, dut_rsp_any = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input int chip, input int len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[63:50] = 14'(chip);
    h[29:22] = 8'(len);
    return h;
  endfunction

  task automatic push_req(input int r, input int len);
    q_req[r].push_back(mk_hdr(int'($urandom_range(0, 15)), len));
    for (int k = 0; k < len; k++) q_req[r].push_back({$urandom, $urandom});
  endtask

  task automatic push_rsp(input int chip, input int len);
    q_rsp.push_back(mk_hdr(chip, len));
    for (int k = 0; k < len; k++) q_rsp.push_back({$urandom, $urandom});
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) q_req[i].delete();
    q_rsp.delete();
  endtask

  task automatic clear_logs();
    grant_log.delete(); src_log.delete(); hs_cyc.delete();
    first_val_cyc = -1;
    for (int i = 0; i < N; i++) dut_rsp_hs[i] = 0;
    dut_drop_cnt = 0; dut_b3_hs = 0; dut_rsp_any = 0;
  endtask

  function automatic bit all_idle();
    bit e;
    e = (q_rsp.size() == 0) && (m_owner < 0) && r_hdr;
    for (int i = 0; i < N; i++) if (q_req[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Stimulus driver: presents queue heads, random garbage when not valid.
  initial forever begin
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (q_req[i].size() != 0 && !kill[i] && $urandom_range(0, 99) < p_val) begin
        req_val[i] = 1'b1;
        req_dat[i*DW +: DW] = q_req[i][0];
      end else begin
        req_val[i] = 1'b0;
        req_dat[i*DW +: DW] = {$urandom, $urandom};
      end
      rsp_rdy[i] = ($urandom_range(0, 99) < p_rrdy) && !rrdy_kill[i];
    end
    br_noc2_rdy = ($urandom_range(0, 99) < p_b2rdy) && !b2_kill;
    if (q_rsp.size() != 0 && $urandom_range(0, 99) < p_b3val) begin
      br_noc3_val = 1'b1;
      br_noc3_dat = q_rsp[0];
    end else begin
      br_noc3_val = 1'b0;
      br_noc3_dat = {$urandom, $urandom};
    end
  end

  // Compare process: expected outputs from the model, then advance the model.
  initial forever begin
    logic [N-1:0] e_rdy, e_rval;
    logic         e_v2, e_r3, e_drop;
    logic [63:0]  e_d2, f;
    logic [13:0]  idx;
    bit           inr, found;
    int           w, len;
    @(negedge clk);
    cyc++;
    e_rdy = '0; e_v2 = 1'b0; e_d2 = '0;
    e_rval = '0; e_r3 = 1'b0; e_drop = 1'b0;
    idx = br_noc3_dat[63:50] - 14'(BASE);
    inr = (idx < 14'(N));
    if (rst_n) begin
      if (m_owner >= 0) begin
        e_v2 = req_val[m_owner];
        e_d2 = req_dat[m_owner*DW +: DW];
        e_rdy[m_owner] = br_noc2_rdy;
      end
      if (r_hdr) begin
        if (inr) begin
          e_rval[int'(idx)] = br_noc3_val;
          e_r3 = rsp_rdy[int'(idx)];
        end else begin
          e_r3 = 1'b1;
          e_drop = br_noc3_val;
        end
      end else if (r_drop) begin
        e_r3 = 1'b1;
      end else begin
        e_rval[r_port] = br_noc3_val;
        e_r3 = rsp_rdy[r_port];
      end
    end
    check("req_rdy", req_rdy, e_rdy);
    check("br_noc2_val", br_noc2_val, e_v2);
    check("br_noc2_dat", br_noc2_dat, e_d2);
    check("br_noc3_rdy", br_noc3_rdy, e_r3);
    check("rsp_val", rsp_val, e_rval);
    check("rsp_drop", rsp_drop, e_drop);
    check("rsp_dat", rsp_dat, br_noc3_dat);

    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_hdr = 1'b0; m_left = 0;
      r_hdr = 1'b1; r_drop = 1'b0; r_left = 0;
    end else begin
      if (first_val_cyc < 0 && req_val != '0) first_val_cyc = cyc;
      if (br_noc2_val && br_noc2_rdy) begin
        for (int i = 0; i < N; i++) if (req_rdy[i]) src_log.push_back(i);
        hs_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) dut_rsp_hs[i] += int'(rsp_val[i] & rsp_rdy[i]);
      dut_drop_cnt += int'(rsp_drop);
      dut_b3_hs    += int'(br_noc3_val & br_noc3_rdy);
      if (rsp_val != '0) dut_rsp_any++;

      if (m_owner < 0) begin
        found = 1'b0; w = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req_val[(m_last + k) % N]) begin
            found = 1'b1;
            w = (m_last + k) % N;
          end
        if (found) begin
          m_owner = w; m_last = w; m_hdr = 1'b1;
          grant_log.push_back(w);
        end
      end else if (e_v2 && br_noc2_rdy && q_req[m_owner].size() != 0) begin
        f = q_req[m_owner].pop_front();
        check("noc2_flit_order", br_noc2_dat, f);
        if (m_hdr) begin
          m_hdr = 1'b0;
          m_left = int'(f[29:22]);
          if (m_left == 0) m_owner = -1;
        end else begin
          m_left--;
          if (m_left == 0) m_owner = -1;
        end
      end

      if (br_noc3_val && e_r3 && q_rsp.size() != 0) begin
        f = q_rsp.pop_front();
        if (r_hdr) begin
          len = int'(f[29:22]);
          if (len > 0) begin
            r_hdr = 1'b0; r_left = len; r_port = int'(idx); r_drop = !inr;
          end
        end else begin
          r_left--;
          if (r_left == 0) r_hdr = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[4];
    int cnt;
    req_val = '0; req_dat = '0; br_noc2_rdy = 1'b0;
    br_noc3_val = 1'b0; br_noc3_dat = '0; rsp_rdy = '0;
    clear_logs();

    // Reset state, with rsp_rdy all high and random NoC3 data on the inputs.
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_noc2_val", br_noc2_val, 0);
    check("rst_noc3_rdy", br_noc3_rdy, 0);
    check("rst_rsp_val", rsp_val, 0);
    check("rst_rsp_drop", rsp_drop, 0);
    rst_n = 1'b1;

    // Single packet, length 2.
    clear_logs();
    @(posedge clk); push_req(0, 2);
    wait_idle("single", 50);
    check("single_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("single_flits", src_log.size(), 3);
    check("single_latency", hs_cyc.size() > 0 ? hs_cyc[0] - first_val_cyc : -1, 1);
    check("single_back2back", hs_cyc.size() == 3 ? hs_cyc[2] - hs_cyc[0] : -1, 2);

    // Round-robin between req1 and req3 from reset.
    apply_reset();
    clear_logs();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin push_req(1, 0); push_req(3, 0); end
    wait_idle("rr", 100);
    exp_rr = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_grant%0d", k), grant_log.size() > k ? grant_log[k] : -1, exp_rr[k]);
    cnt = 0;
    foreach (src_log[k]) if (src_log[k] == 0 || src_log[k] == 2) cnt++;
    check("rr_no_req0_req2", cnt, 0);

    // Locking: req2 arrives while req0 holds a length-4 packet, with stalls.
    clear_logs();
    @(posedge clk); push_req(0, 4);
    cnt = 0;
    while (m_owner != 0 && cnt < 20) begin @(negedge clk); #1; cnt++; end
    @(posedge clk); push_req(2, 0);
    b2_kill = 1'b1; kill[0] = 1'b1;
    repeat (2) @(posedge clk);
    kill[0] = 1'b0;
    @(posedge clk);
    b2_kill = 1'b0;
    wait_idle("lock", 100);
    check("lock_grants", grant_log.size(), 2);
    check("lock_second_grant", grant_log.size() > 1 ? grant_log[1] : -1, 2);
    check("lock_flits", src_log.size(), 6);
    cnt = 0;
    for (int k = 0; k < 5 && k < src_log.size(); k++) if (src_log[k] == 0) cnt++;
    check("lock_req0_first", cnt, 5);

    // Response routing with back-pressure on port 2.
    clear_logs();
    @(posedge clk);
    rrdy_kill = 4'b0100;
    push_rsp(2, 1); push_rsp(0, 0);
    @(posedge clk); #2;
    check("rsp_stall_rdy", br_noc3_rdy, 0);
    check("rsp_stall_val", rsp_val, 4'b0100);
    @(posedge clk); rrdy_kill = '0;
    wait_idle("rsp", 50);
    check("rsp_port2_flits", dut_rsp_hs[2], 2);
    check("rsp_port0_flits", dut_rsp_hs[0], 1);
    check("rsp_other_flits", dut_rsp_hs[1] + dut_rsp_hs[3], 0);

    // Out-of-range chipid drop.
    clear_logs();
    @(posedge clk); push_rsp(9, 3);
    wait_idle("drop", 50);
    check("drop_accepted", dut_b3_hs, 4);
    check("drop_pulses", dut_drop_cnt, 1);
    check("drop_rsp_val", dut_rsp_any, 0);

    // Randomised traffic including maximum-length packets.
    clear_logs();
    p_val = 70; p_b2rdy = 65; p_b3val = 70; p_rrdy = 60;
    @(posedge clk);
    push_req(1, 255); push_rsp(3, 255);
    for (int k = 0; k < 40; k++) begin
      push_req(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 6)));
      push_rsp(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
    end
    wait_idle("random", 20000);
    p_val = 100; p_b2rdy = 100; p_b3val = 100; p_rrdy = 100;

    // Reset during a body with five flits still owed.
    clear_logs();
    @(posedge clk); push_req(0, 7);
    cnt = 0;
    while (!(m_owner == 0 && !m_hdr && m_left == 5) && cnt < 30) begin
      @(negedge clk); #1; cnt++;
    end
    @(posedge clk); #3;
    check("rst_mid_pre_val", br_noc2_val, 1);
    rst_n = 1'b0;
    flush();
    #1;
    check("rst_mid_req_rdy", req_rdy, 0);
    check("rst_mid_noc2_val", br_noc2_val, 0);
    check("rst_mid_noc2_dat", br_noc2_dat, 0);
    check("rst_mid_noc3_rdy", br_noc3_rdy, 0);
    check("rst_mid_rsp_val", rsp_val, 0);
    check("rst_mid_rsp_drop", rsp_drop, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_logs();
    @(posedge clk); push_req(2, 0); push_req(0, 1);
    wait_idle("post_reset", 50);
    check("post_rst_grant0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("post_rst_grant1", grant_log.size() > 1 ? grant_log[1] : -1, 2);
    check("post_rst_flits", src_log.size(), 3);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_offchip_arbiter.md
Name: noc_offchip_arbiter

Overview:
- Shares one off-chip NoC2/NoC3 channel pair between NUM_REQ requesters, each a chip/tile cluster with its own val/rdy NoC interface.
- Sits between the credit-to-valrdy converters and the single noc_axi4_bridge.
- NoC2 requests are arbitrated round-robin with whole-packet locking.
- NoC3 responses are routed back to a requester by the destination chipid field of the header flit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 64, NoC flit width (`NOC_DATA_WIDTH).
- CHIPID_BASE, 0, chipid of requester 0; requester i owns chipid CHIPID_BASE+i.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_val  in  NUM_REQ  per-requester NoC2 flit valid.
- req_dat  in  NUM_REQ*DW  per-requester NoC2 flit; requester i occupies bits [i*DW +: DW].
- req_rdy  out  NUM_REQ  per-requester NoC2 ready.
- br_noc2_val  out  1  NoC2 flit valid to the bridge.
- br_noc2_dat  out  DW  NoC2 flit to the bridge.
- br_noc2_rdy  in  1  bridge ready.
- br_noc3_val  in  1  NoC3 response flit valid from the bridge.
- br_noc3_dat  in  DW  NoC3 response flit.
- br_noc3_rdy  out  1  ready to the bridge.
- rsp_val  out  NUM_REQ  per-requester response valid.
- rsp_dat  out  DW  response flit, broadcast to all requesters.
- rsp_rdy  in  NUM_REQ  per-requester response ready.
- rsp_drop  out  1  one-cycle pulse when a response packet header is dropped.

Behaviour:
- Header flit fields: chipid = dat[63:50]; payload length = dat[29:22], counting flits after the header.
- A handshake is val & rdy in the same cycle.
- Reset values: req_rdy=0, br_noc2_val=0, br_noc3_rdy=0, rsp_val=0, rsp_drop=0, rr_ptr=NUM_REQ-1, both FSMs idle, counters 0.

Request FSM (R_IDLE, R_HDR, R_BODY):
- R_IDLE:
  - No ready asserted and no output valid.
  - If any req_val is set, the winner is the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - grant <= winner; rr_ptr <= winner; go to R_HDR.
  - This costs one bubble cycle per packet.
- R_HDR and R_BODY:
  - br_noc2_val = req_val[grant]; br_noc2_dat = req_dat[grant].
  - req_rdy[grant] = br_noc2_rdy; all other req_rdy bits = 0.
  - Valid and data pass through combinationally; no flit buffering.
- R_HDR, on handshake:
  - length==0: go to R_IDLE.
  - Otherwise: rcnt <= length; go to R_BODY.
- R_BODY, on handshake: rcnt <= rcnt-1; when rcnt==1, go to R_IDLE.
- Packet locking:
  - No other requester is granted until the tail flit transfers.
  - Withdrawal of req_val mid-packet holds the lock and stalls the output.
- A length of 255 gives 256 flits; the counter is 8 bits and cannot overflow.

Response FSM (S_HDR, S_BODY), independent of the request FSM:
- S_HDR:
  - idx = chipid - CHIPID_BASE, computed unsigned in 14 bits; in-range means idx < NUM_REQ.
  - In range: rsp_val[idx] = br_noc3_val; br_noc3_rdy = rsp_rdy[idx].
  - Out of range: rsp_val = 0; br_noc3_rdy = 1; rsp_drop pulses on the header handshake.
  - On header handshake with length>0: latch port <= idx, drop <= !in-range, scnt <= length; go to S_BODY.
- S_BODY:
  - Routes to the latched port, or sinks the flits if drop is set.
  - Decrements scnt per handshake; returns to S_HDR after the flit where scnt==1.
- rsp_dat = br_noc3_dat at all times.

Concurrency and reset:
- The request and response paths advance in the same cycle without interaction.
- Asynchronous reset mid-packet returns both FSMs to idle immediately; partial packets are discarded, not completed.

Test Plan:
- Single packet: req0 sends a header with length=2 plus 2 body flits, br_noc2_rdy=1.
  - Required: grant to req0 one cycle after req_val; 3 flits out on consecutive cycles; FSM back to R_IDLE.
- Round-robin: req1 and req3 both hold length-0 packets continuously, starting from reset.
  - Required: grant order 1,3,1,3; req0 and req2 are never granted.
- Locking: req0 is mid-packet (length=4) and req2 asserts req_val.
  - Drop br_noc2_rdy for 3 cycles; also drop req0 val for 2 cycles.
  - Required: req2 is never granted until req0's tail flit transfers; no flit is duplicated or lost.
- Response routing, CHIPID_BASE=0: headers with chipid 2 and length 1, then chipid 0 and length 0.
  - Required: both flits of the first packet appear only on rsp_val[2]; the second appears only on rsp_val[0].
  - Back-pressure on rsp_rdy[2] stalls br_noc3_rdy.
- Drop: response header with chipid=9 (NUM_REQ=4) and length=3.
  - Required: 4 flits accepted with br_noc3_rdy=1; rsp_val stays 0; rsp_drop pulses exactly once.
- Reset: assert rst_n=0 during R_BODY with rcnt=5.
  - Required: all outputs are 0 asynchronously.
  - After release, the next grant starts from requester 0 (rr_ptr=NUM_REQ-1), and the next flit is treated as a header.
